settings_bus_deframer: RTL and testbench

SETTINGS_BUS_DEFRAMER -- requirements
Module: settings_bus_deframer

---
 rtl/settings_bus_deframer_pkg.sv | 14 +
 rtl/settings_bus_deframer.sv | 141 ++++++++++++++
 tb/tb_settings_bus_deframer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/settings_bus_deframer_pkg.sv
// Shared constants and state type for the settings bus deframer.
package settings_bus_deframer_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int         BODY_LEN  = 5;

    typedef enum logic [1:0] {
        HUNT,
        BODY,
        CSUM,
        STROBE
    } state_t;

endpackage

// File: rtl/settings_bus_deframer.sv
// Turns a byte stream of SYNC/ADDR/D3..D0/CSUM frames into settings bus writes,
// counting checksum and inter-byte timeout errors.
module settings_bus_deframer
    import settings_bus_deframer_pkg::*;
#(
    parameter int awidth  = 7,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              set_stb,
    output logic [awidth-1:0] set_addr,
    output logic [31:0]       set_data,
    output logic [15:0]       err_cnt
);

    localparam int             IW         = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0]  IDLE_LIMIT = IW'(TIMEOUT - 1);
    localparam logic [2:0]     LAST_IDX   = 3'(BODY_LEN - 1);

    state_t        state;
    state_t        next_state;
    logic [2:0]    idx;
    logic [IW-1:0] idle_cnt;
    logic [7:0]    run_xor;
    logic [7:0]    cap_addr;
    logic [31:0]   cap_data;
    logic          accept;
    logic          in_frame;
    logic          timeout;
    logic          csum_ok;
    logic          csum_err;

    assign accept   = in_valid && in_ready;
    assign in_frame = (state == BODY) || (state == CSUM);
    // An accepted byte always beats the idle limit, so the two errors are exclusive.
    assign timeout  = in_frame && !accept && (idle_cnt == IDLE_LIMIT);
    assign csum_ok  = (state == CSUM) && accept && (in_data == run_xor);
    assign csum_err = (state == CSUM) && accept && (in_data != run_xor);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HUNT;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            HUNT: begin
                if (accept && in_data == SYNC_BYTE) begin
                    next_state = BODY;
                end
            end
            BODY: begin
                if (accept) begin
                    if (idx == LAST_IDX) begin
                        next_state = CSUM;
                    end
                end else if (timeout) begin
                    next_state = HUNT;
                end
            end
            CSUM: begin
                if (csum_ok) begin
                    next_state = STROBE;
                end else if (csum_err || timeout) begin
                    next_state = HUNT;
                end
            end
            STROBE: begin
                next_state = HUNT;
            end
            default: begin
                next_state = HUNT;
            end
        endcase
    end

    always_comb begin
        in_ready = (state != STROBE);
        set_stb  = (state == STROBE);
    end

    // Capture, checksum and idle tracking; outputs load only on a good checksum.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx      <= '0;
            idle_cnt <= '0;
            run_xor  <= '0;
            cap_addr <= '0;
            cap_data <= '0;
            set_addr <= '0;
            set_data <= '0;
            err_cnt  <= '0;
        end else begin
            case (state)
                HUNT: begin
                    if (accept && in_data == SYNC_BYTE) begin
                        idx      <= '0;
                        idle_cnt <= '0;
                        run_xor  <= '0;
                    end
                end
                BODY, CSUM: begin
                    if (accept) begin
                        idle_cnt <= '0;
                        if (state == BODY) begin
                            idx     <= idx + 3'd1;
                            run_xor <= run_xor ^ in_data;
                            if (idx == 3'd0) begin
                                cap_addr <= in_data;
                            end else begin
                                cap_data <= {cap_data[23:0], in_data};
                            end
                        end else if (csum_ok) begin
                            set_addr <= awidth'(cap_addr);
                            set_data <= cap_data;
                        end
                    end else if (timeout) begin
                        idle_cnt <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + IW'(1);
                    end
                end
                default: begin
                end
            endcase

            if ((csum_err || timeout) && err_cnt != 16'hFFFF) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_settings_bus_deframer.sv
// Directed bench for settings_bus_deframer: framing, checksum, timeout, back-to-back
// and mid-frame reset, with hand-computed expectations.
module tb_settings_bus_deframer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        set_stb;
    logic [6:0]  set_addr;
    logic [31:0] set_data;
    logic [15:0] err_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int stb_count = 0;
    int last_stb_cyc = 0;
    int prev_stb_cyc = 0;
    int ready_bad = 0;
    int not_ready_valid = 0;
    int nr_before;

    localparam logic [55:0] GOOD     = 56'hA5_12_DE_AD_BE_EF_30;
    localparam logic [55:0] BAD      = 56'hA5_12_DE_AD_BE_EF_31;
    localparam logic [55:0] ALL_SYNC = 56'hA5_A5_A5_A5_A5_A5_A5;

    settings_bus_deframer #(.awidth(7), .TIMEOUT(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .set_stb  (set_stb),
        .set_addr (set_addr),
        .set_data (set_data),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Observe strobes and the ready/strobe relationship mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (set_stb) begin
                stb_count++;
                prev_stb_cyc = last_stb_cyc;
                last_stb_cyc = cyc;
            end
            if (in_ready == set_stb) ready_bad++;
            if (in_valid && !in_ready) not_ready_valid++;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [7:0] b);
        bit done;
        done = 1'b0;
        in_data  = b;
        in_valid = 1'b1;
        for (int i = 0; i < 32 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        if (!done) check_output("accept_bound", 32'(done), 32'd1);
    endtask

    task automatic send_frame(input logic [55:0] f, input bit keep_valid);
        for (int i = 0; i < 7; i++) apply_stimulus(f[55 - 8*i -: 8]);
        if (!keep_valid) in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        $display("[TB] start");
        do_reset();
        check_output("rst_in_ready", 32'(in_ready), 32'd1);
        check_output("rst_set_stb", 32'(set_stb), 32'd0);
        check_output("rst_set_addr", 32'(set_addr), 32'h0);
        check_output("rst_set_data", set_data, 32'h0);
        check_output("rst_err_cnt", 32'(err_cnt), 32'd0);

        // Good frame: strobe exactly one cycle after the checksum byte.
        send_frame(GOOD, 1'b0);
        check_output("good_stb", 32'(set_stb), 32'd1);
        check_output("good_addr", 32'(set_addr), 32'h12);
        check_output("good_data", set_data, 32'hDEADBEEF);
        check_output("good_ready_low", 32'(in_ready), 32'd0);
        idle(1);
        check_output("good_stb_width", 32'(set_stb), 32'd0);
        check_output("good_addr_hold", 32'(set_addr), 32'h12);
        check_output("good_err", 32'(err_cnt), 32'd0);
        check_output("good_stb_count", 32'(stb_count), 32'd1);

        // Bad checksum, then a normal frame.
        send_frame(BAD, 1'b0);
        idle(2);
        check_output("bad_no_stb", 32'(stb_count), 32'd1);
        check_output("bad_err", 32'(err_cnt), 32'd1);
        check_output("bad_data_hold", set_data, 32'hDEADBEEF);
        send_frame(GOOD, 1'b0);
        check_output("after_bad_stb", 32'(set_stb), 32'd1);
        idle(2);
        check_output("after_bad_count", 32'(stb_count), 32'd2);

        // Leading garbage is discarded silently.
        apply_stimulus(8'h00);
        apply_stimulus(8'hFF);
        apply_stimulus(8'h5A);
        send_frame(GOOD, 1'b0);
        idle(2);
        check_output("garbage_count", 32'(stb_count), 32'd3);
        check_output("garbage_err", 32'(err_cnt), 32'd1);

        // 0xA5 inside the body is data; ADDR bit 7 is dropped from the address.
        send_frame(ALL_SYNC, 1'b0);
        check_output("sync_data_stb", 32'(set_stb), 32'd1);
        check_output("sync_data_addr", 32'(set_addr), 32'h25);
        check_output("sync_data_data", set_data, 32'hA5A5A5A5);
        idle(2);
        check_output("sync_data_err", 32'(err_cnt), 32'd1);

        // Timeout after A5 12 DE with a long idle gap; the next frame parses from HUNT.
        apply_stimulus(8'hA5);
        apply_stimulus(8'h12);
        apply_stimulus(8'hDE);
        idle(20);
        check_output("timeout_err", 32'(err_cnt), 32'd2);
        check_output("timeout_no_stb", 32'(stb_count), 32'd4);
        send_frame(GOOD, 1'b0);
        check_output("timeout_recover_data", set_data, 32'hDEADBEEF);
        idle(2);
        check_output("timeout_recover_count", 32'(stb_count), 32'd5);

        // Byte arriving on the limit cycle (15 idle cycles) wins.
        apply_stimulus(8'hA5);
        apply_stimulus(8'h12);
        idle(15);
        apply_stimulus(8'hDE);
        apply_stimulus(8'hAD);
        apply_stimulus(8'hBE);
        apply_stimulus(8'hEF);
        apply_stimulus(8'h30);
        in_valid = 1'b0;
        check_output("limit_stb", 32'(set_stb), 32'd1);
        idle(2);
        check_output("limit_err", 32'(err_cnt), 32'd2);

        // One more idle cycle than that times out and the rest is discarded.
        apply_stimulus(8'hA5);
        apply_stimulus(8'h12);
        idle(16);
        apply_stimulus(8'hDE);
        apply_stimulus(8'hAD);
        apply_stimulus(8'hBE);
        apply_stimulus(8'hEF);
        apply_stimulus(8'h30);
        idle(3);
        check_output("over_limit_err", 32'(err_cnt), 32'd3);
        check_output("over_limit_count", 32'(stb_count), 32'd6);

        // Back-to-back frames with in_valid held high.
        nr_before = not_ready_valid;
        send_frame(GOOD, 1'b1);
        send_frame(ALL_SYNC, 1'b0);
        check_output("b2b_addr", 32'(set_addr), 32'h25);
        idle(2);
        check_output("b2b_count", 32'(stb_count), 32'd8);
        check_output("b2b_spacing", 32'(last_stb_cyc - prev_stb_cyc), 32'd8);
        check_output("b2b_not_ready", 32'(not_ready_valid - nr_before), 32'd1);

        // Reset after D2 discards the partial frame.
        apply_stimulus(8'hA5);
        apply_stimulus(8'h12);
        apply_stimulus(8'hDE);
        apply_stimulus(8'hAD);
        do_reset();
        check_output("midrst_addr", 32'(set_addr), 32'h0);
        check_output("midrst_err", 32'(err_cnt), 32'd0);
        send_frame(GOOD, 1'b0);
        check_output("midrst_data", set_data, 32'hDEADBEEF);
        idle(3);
        check_output("midrst_count", 32'(stb_count), 32'd9);
        check_output("midrst_err_after", 32'(err_cnt), 32'd0);

        check_output("ready_vs_stb", 32'(ready_bad), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
